// File: rtl/mux_arbiter.sv
// Round-robin packet arbiter for two valid/ready requesters sharing one output
// channel through a one-hot 2:1 mux and a single-entry output register.

module mux_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic                  a_last,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic                  b_last,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  sel1,
  output logic                  sel2,
  output logic                  busy,
  output logic                  err_overrun
);

  localparam int               CNT_W    = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] GRANT_A = 2'b01;
  localparam logic [1:0] GRANT_B = 2'b10;

  logic [1:0]            state_q, state_d;
  logic                  prio_q, prio_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  err_overrun_q, err_overrun_d;

  logic                  slot_free;
  logic                  load;
  logic                  x_last;
  logic                  cap_hit;
  logic                  release_grant;
  logic [DATA_WIDTH-1:0] mux_out;

  function automatic logic [1:0] arbitrate(input logic av, input logic bv, input logic p);
    if (av && bv) return p ? GRANT_B : GRANT_A;
    if (av)       return GRANT_A;
    if (bv)       return GRANT_B;
    return IDLE;
  endfunction

  assign sel1 = (state_q == GRANT_A);
  assign sel2 = (state_q == GRANT_B);
  assign busy = sel1 | sel2;

  assign slot_free     = !out_valid_q || out_ready;
  assign a_ready       = sel1 & slot_free;
  assign b_ready       = sel2 & slot_free;
  assign load          = (a_valid & a_ready) | (b_valid & b_ready);
  assign x_last        = sel1 ? a_last : b_last;
  assign cap_hit       = (beat_cnt_q == LAST_CNT);
  assign release_grant = load & (x_last | cap_hit);

  mux_arbiter_mux2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .sel1 (sel1),
    .sel2 (sel2),
    .in1  (a_data),
    .in2  (b_data),
    .out  (mux_out)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d       = state_q;
    prio_d        = prio_q;
    beat_cnt_d    = beat_cnt_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_data_d    = out_data_q;
    err_overrun_d = 1'b0;

    if (load) begin
      out_data_d  = mux_out;
      out_last_d  = x_last;
      out_valid_d = 1'b1;
      beat_cnt_d  = beat_cnt_q + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: state_d = arbitrate(a_valid, b_valid, prio_q);
      GRANT_A, GRANT_B: begin
        if (release_grant) begin
          beat_cnt_d    = '0;
          prio_d        = sel1;
          err_overrun_d = !x_last;
          // The releasing side's valid is the beat just consumed, so only the
          // other requester may take over without an IDLE cycle.
          state_d       = arbitrate(a_valid & ~sel1, b_valid & ~sel2, prio_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      beat_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      beat_cnt_q    <= beat_cnt_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_data_q    <= out_data_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign err_overrun = err_overrun_q;

endmodule

module mux_arbiter_mux2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sel1,
  input  logic                  sel2,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic [DATA_WIDTH-1:0] out
);

  assign out = ({DATA_WIDTH{sel1}} & in1) | ({DATA_WIDTH{sel2}} & in2);

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.

module tb_mux_arbiter;

  localparam int DW = 32;
  localparam int MB = 4;

  typedef logic [DW:0] beat_t;  // {last, data}

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, a_last = 1'b0;
  logic          b_valid = 1'b0, b_last = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          out_ready = 1'b1;
  logic          a_ready, b_ready, out_valid, out_last;
  logic          sel1, sel2, busy, err_overrun;
  logic [DW-1:0] out_data;

  mux_arbiter #(
    .DATA_WIDTH(DW),
    .MAX_BEATS (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_last     (a_last),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_last     (b_last),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .sel1       (sel1),
    .sel2       (sel2),
    .busy       (busy),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t qa[$], qb[$], obs[$], exp_q[$];
  bit    a_en = 1'b1, b_en = 1'b1;
  bit    a_acc = 1'b0, b_acc = 1'b0;
  bit    track = 1'b0;
  int    err_seen = 0;
  int    idle_gap = 0;

  // Reference model: who owns the channel (0 none, 1 A, 2 B), whose turn it
  // is on a tie, beats taken in this grant, and the output slot contents.
  int          m_owner = 0;
  bit          m_prio  = 1'b0;
  int          m_cnt   = 0;
  bit          m_ov    = 1'b0;
  bit          m_ol    = 1'b0;
  bit          m_err   = 1'b0;
  logic [DW-1:0] m_od  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit av, input bit bv, input bit p);
    if (av && bv) return p ? 2 : 1;
    if (av)       return 1;
    if (bv)       return 2;
    return 0;
  endfunction

  task automatic model_step();
    int cur;
    bit take;
    bit lst;
    int other;
    if (rst) begin
      m_owner = 0; m_prio = 1'b0; m_cnt = 0;
      m_ov = 1'b0; m_ol = 1'b0; m_od = '0; m_err = 1'b0;
      a_acc = 1'b0; b_acc = 1'b0;
    end else begin
      cur   = m_owner;
      take  = (cur == 1) ? a_valid : (cur == 2) ? b_valid : 1'b0;
      take  = take && (!m_ov || out_ready);
      a_acc = take && (cur == 1);
      b_acc = take && (cur == 2);
      m_err = 1'b0;
      if (take) begin
        lst  = (cur == 1) ? a_last : b_last;
        m_od = (cur == 1) ? a_data : b_data;
        m_ol = lst;
        m_ov = 1'b1;
        m_cnt++;
        // A grant ends on a last beat or after MB beats; the other side then
        // gets the channel if it is waiting.
        if (lst || m_cnt == MB) begin
          m_err   = !lst;
          m_cnt   = 0;
          m_prio  = (cur == 1);
          other   = 3 - cur;
          m_owner = ((other == 1) ? a_valid : b_valid) ? other : 0;
        end
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (cur == 0) m_owner = pick(a_valid, b_valid, m_prio);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Requester sources: present the queue head, pop once it is accepted.
  initial forever begin
    @(negedge clk);
    if (a_acc && qa.size() > 0) void'(qa.pop_front());
    if (b_acc && qb.size() > 0) void'(qb.pop_front());
    a_valid = a_en && qa.size() > 0;
    b_valid = b_en && qb.size() > 0;
    if (qa.size() > 0) {a_last, a_data} = qa[0];
    if (qb.size() > 0) {b_last, b_data} = qb[0];
  end

  // Per-cycle comparison against the model, plus output-stream capture.
  initial forever begin
    @(negedge clk);
    #2;
    check("sel1",        sel1,        m_owner == 1);
    check("sel2",        sel2,        m_owner == 2);
    check("busy",        busy,        m_owner != 0);
    check("a_ready",     a_ready,     m_owner == 1 && (!m_ov || out_ready));
    check("b_ready",     b_ready,     m_owner == 2 && (!m_ov || out_ready));
    check("out_valid",   out_valid,   m_ov);
    check("out_last",    out_last,    m_ol);
    check("out_data",    out_data,    m_od);
    check("err_overrun", err_overrun, m_err);
    if (out_valid && out_ready) obs.push_back({out_last, out_data});
    if (err_overrun) err_seen++;
    if (track && !busy && (qa.size() + qb.size()) > 0) idle_gap++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input bit to_b, input logic [DW-1:0] d, input bit last);
    if (to_b) qb.push_back({last, d});
    else      qa.push_back({last, d});
  endtask

  task automatic expect_beat(input bit last, input logic [DW-1:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic push_packet(input bit to_b, input int len);
    for (int i = 0; i < len; i++) push(to_b, $urandom, i == len - 1);
  endtask

  task automatic wait_obs(input string tag, input int n, input int budget);
    int left;
    left = budget;
    while (obs.size() < n && left > 0) begin
      next_cyc();
      left--;
    end
    if (obs.size() < n) check({tag, "_timeout"}, obs.size(), n);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), obs[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    qa.delete(); qb.delete();
    a_en = 1'b1; b_en = 1'b1; out_ready = 1'b1;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    obs.delete(); exp_q.delete();
    err_seen = 0; idle_gap = 0; track = 1'b0;
    next_cyc();
  endtask

  initial begin
    next_cyc();
    check("reset_sel1",      sel1,      1'b0);
    check("reset_busy",      busy,      1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data",  out_data,  32'h0);
    do_reset();

    // Single three-beat packet from A.
    push(0, 32'h11, 0); push(0, 32'h22, 0); push(0, 32'h33, 1);
    next_cyc(); next_cyc();
    check("pkt_a_grant_sel1", sel1, 1'b1);
    check("pkt_a_grant_sel2", sel2, 1'b0);
    wait_obs("pkt_a", 3, 20);
    next_cyc(); next_cyc();
    expect_beat(0, 32'h11); expect_beat(0, 32'h22); expect_beat(1, 32'h33);
    check_stream("pkt_a");
    check("pkt_a_idle_sel1", sel1, 1'b0);
    check("pkt_a_idle_sel2", sel2, 1'b0);

    // Tie from reset, alternating with no IDLE bubble.
    do_reset();
    push(0, 32'hA1, 0); push(0, 32'hA2, 1); push(0, 32'hA3, 1);
    push(1, 32'hB1, 0); push(1, 32'hB2, 1); push(1, 32'hB3, 1);
    next_cyc(); next_cyc();
    check("tie_first_sel1", sel1, 1'b1);
    check("tie_first_sel2", sel2, 1'b0);
    track = 1'b1;
    wait_obs("tie", 6, 40);
    track = 1'b0;
    expect_beat(0, 32'hA1); expect_beat(1, 32'hA2);
    expect_beat(0, 32'hB1); expect_beat(1, 32'hB2);
    expect_beat(1, 32'hA3); expect_beat(1, 32'hB3);
    check_stream("tie");
    check("tie_idle_gap", idle_gap, 0);

    // Backpressure mid-packet for four cycles.
    do_reset();
    for (int i = 0; i < 6; i++) push(0, 32'hC0 + i, i == 5);
    wait_obs("bp_pre", 2, 20);
    out_ready = 1'b0;
    repeat (4) begin
      #1;
      check("bp_hold_data",  out_data,  32'hC2);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_a_ready",    a_ready,   1'b0);
      next_cyc();
    end
    out_ready = 1'b1;
    wait_obs("bp", 6, 30);
    for (int i = 0; i < 6; i++) expect_beat(i == 5, 32'hC0 + i);
    check_stream("bp");

    // Overrun: A streams six beats with no last while B waits.
    do_reset();
    for (int i = 0; i < 6; i++) push(0, 32'hD0 + i, 0);
    push(1, 32'hE0, 1);
    wait_obs("ovr", 7, 40);
    next_cyc();
    for (int i = 0; i < 4; i++) expect_beat(0, 32'hD0 + i);
    expect_beat(1, 32'hE0);
    expect_beat(0, 32'hD4); expect_beat(0, 32'hD5);
    check_stream("ovr");
    check("ovr_err_pulses", err_seen, 1);
    check("ovr_grant_held", sel1, 1'b1);

    // Asynchronous reset during a B packet.
    do_reset();
    for (int i = 0; i < 4; i++) push(1, 32'hF0 + i, i == 3);
    wait_obs("rstmid_pre", 1, 20);
    rst = 1'b1;
    #1;
    check("rstmid_sel1",      sel1,        1'b0);
    check("rstmid_sel2",      sel2,        1'b0);
    check("rstmid_busy",      busy,        1'b0);
    check("rstmid_a_ready",   a_ready,     1'b0);
    check("rstmid_b_ready",   b_ready,     1'b0);
    check("rstmid_out_valid", out_valid,   1'b0);
    check("rstmid_out_last",  out_last,    1'b0);
    check("rstmid_out_data",  out_data,    32'h0);
    check("rstmid_err",       err_overrun, 1'b0);
    qa.delete(); qb.delete();
    next_cyc(); next_cyc();
    obs.delete();
    rst = 1'b0;
    push(0, 32'h61, 1); push(1, 32'h71, 1);
    next_cyc(); next_cyc();
    check("rstmid_regrant_sel1", sel1, 1'b1);
    check("rstmid_regrant_sel2", sel2, 1'b0);
    wait_obs("rstmid", 2, 20);
    expect_beat(1, 32'h61); expect_beat(1, 32'h71);
    check_stream("rstmid");

    // Randomized traffic, stalls and valid gaps, checked by the model.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      if (qa.size() < 6 && $urandom_range(0, 3) == 0) push_packet(0, $urandom_range(1, 6));
      if (qb.size() < 6 && $urandom_range(0, 3) == 0) push_packet(1, $urandom_range(1, 6));
      a_en      = $urandom_range(0, 9) < 8;
      b_en      = $urandom_range(0, 9) < 8;
      out_ready = $urandom_range(0, 9) < 7;
      next_cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
